ncu_sii_ingress: RTL

//  NCU-side receiver for the SII->NCU inbound path (Mondo interrupts, PIO completions).

---
 rtl/ncu_sii_pkg.sv | 28 ++
 rtl/ncu_sii_ingress_if.sv | 34 +++
 rtl/ncu_sii_pkt_fifo.sv | 66 ++++++
 rtl/ncu_sii_ingress.sv | 127 ++++++++++++
 4 files changed

// File: rtl/ncu_sii_pkg.sv
// rtl/ncu_sii_pkg.sv - shared types, widths and parity helper for the SII->NCU ingress path
package ncu_sii_pkg;

  localparam int NCU_SII_PL_BEATS = 4;
  localparam int NCU_SII_BEAT_W   = 32;
  localparam int NCU_SII_PL_W     = NCU_SII_PL_BEATS * NCU_SII_BEAT_W;
  localparam int NCU_SII_ENTRY_W  = NCU_SII_BEAT_W + NCU_SII_PL_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_HDR  = 2'd2,
    ST_PL   = 2'd3
  } ncu_sii_state_e;

  // One FIFO entry: header, 4 payload beats (beat0 in the MSBs), sticky parity error.
  typedef struct packed {
    logic [NCU_SII_BEAT_W-1:0] hdr;
    logic [NCU_SII_PL_W-1:0]   data;
    logic                      perr;
  } ncu_sii_pkt_t;

  // High when either 16-bit half of a payload beat disagrees with its parity bit.
  function automatic logic beat_perr(input logic [NCU_SII_BEAT_W-1:0] d, input logic [1:0] p);
    return (p[0] != ^d[15:0]) || (p[1] != ^d[31:16]);
  endfunction

endpackage

// File: rtl/ncu_sii_ingress_if.sv
// rtl/ncu_sii_ingress_if.sv - SII request/data bus and NCU packet interface bundle
interface ncu_sii_ingress_if
  import ncu_sii_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                      sii_ncu_req;
  logic [NCU_SII_BEAT_W-1:0] sii_ncu_data;
  logic [1:0]                sii_ncu_dparity;
  logic                      ncu_sii_gnt;
  logic                      ncu_pkt_vld;
  logic                      ncu_pkt_rdy;
  logic [NCU_SII_BEAT_W-1:0] ncu_pkt_hdr;
  logic [NCU_SII_PL_W-1:0]   ncu_pkt_data;
  logic                      ncu_pkt_perr;
  logic                      ncu_sii_perr;
  logic [CNT_W-1:0]          ncu_pkt_cnt;

  // Environment side: the SII source and the NCU core sink.
  modport master (
    output sii_ncu_req, sii_ncu_data, sii_ncu_dparity, ncu_pkt_rdy,
    input  ncu_sii_gnt, ncu_pkt_vld, ncu_pkt_hdr, ncu_pkt_data,
    input  ncu_pkt_perr, ncu_sii_perr, ncu_pkt_cnt
  );

  // Ingress block side.
  modport slave (
    input  sii_ncu_req, sii_ncu_data, sii_ncu_dparity, ncu_pkt_rdy,
    output ncu_sii_gnt, ncu_pkt_vld, ncu_pkt_hdr, ncu_pkt_data,
    output ncu_pkt_perr, ncu_sii_perr, ncu_pkt_cnt
  );

endinterface

// File: rtl/ncu_sii_pkt_fifo.sv
// rtl/ncu_sii_pkt_fifo.sv - show-ahead packet FIFO with occupancy count
module ncu_sii_pkt_fifo
  import ncu_sii_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = NCU_SII_ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   vld,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // Next-state: pop from empty is dropped; push when full only lands if a pop frees the slot.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != FULL) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  // Storage and pointers; entries clear on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign vld   = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/ncu_sii_ingress.sv
// rtl/ncu_sii_ingress.sv - SII->NCU inbound packet receiver: grant, capture, parity, buffer
module ncu_sii_ingress
  import ncu_sii_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             iol2clk,
  input  logic             rst_l,
  ncu_sii_ingress_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam int          PART_W   = NCU_SII_PL_W - NCU_SII_BEAT_W;

  ncu_sii_state_e            state_q, state_d;
  logic [1:0]                beat_q, beat_d;
  logic [NCU_SII_BEAT_W-1:0] hdr_q, hdr_d;
  logic [PART_W-1:0]         pl_q, pl_d;
  logic                      perr_acc_q, perr_acc_d;
  logic                      gnt_q, gnt_d;
  logic                      sii_perr_q, sii_perr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      beat_err;
  logic                      push;
  logic [AW:0]               fifo_count;
  ncu_sii_pkt_t              pkt_in;
  ncu_sii_pkt_t              pkt_out;

  assign beat_err = beat_perr(bus.sii_ncu_data, bus.sii_ncu_dparity);

  // The last beat bypasses the shift register so the packet is pushed on its own edge.
  assign pkt_in.hdr  = hdr_q;
  assign pkt_in.data = {pl_q, bus.sii_ncu_data};
  assign pkt_in.perr = perr_acc_q | beat_err;

  // Transfer sequencing: grant only from IDLE with room, then header and four payload beats.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    hdr_d      = hdr_q;
    pl_d       = pl_q;
    perr_acc_d = perr_acc_q;
    gnt_d      = 1'b0;
    sii_perr_d = 1'b0;
    cnt_d      = cnt_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.sii_ncu_req && (fifo_count != FULL_CNT)) begin
          state_d = ST_GNT;
          gnt_d   = 1'b1;
        end
      end
      ST_GNT: begin
        state_d = ST_HDR;
      end
      ST_HDR: begin
        hdr_d      = bus.sii_ncu_data;
        beat_d     = 2'd0;
        perr_acc_d = 1'b0;
        state_d    = ST_PL;
      end
      ST_PL: begin
        pl_d       = {pl_q[PART_W-NCU_SII_BEAT_W-1:0], bus.sii_ncu_data};
        perr_acc_d = perr_acc_q | beat_err;
        beat_d     = beat_q + 2'd1;
        if (beat_q == 2'(NCU_SII_PL_BEATS - 1)) begin
          push       = 1'b1;
          sii_perr_d = pkt_in.perr;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, capture registers and registered status outputs.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      beat_q     <= 2'd0;
      hdr_q      <= '0;
      pl_q       <= '0;
      perr_acc_q <= 1'b0;
      gnt_q      <= 1'b0;
      sii_perr_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      hdr_q      <= hdr_d;
      pl_q       <= pl_d;
      perr_acc_q <= perr_acc_d;
      gnt_q      <= gnt_d;
      sii_perr_q <= sii_perr_d;
      cnt_q      <= cnt_d;
    end
  end

  ncu_sii_pkt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NCU_SII_ENTRY_W)
  ) u_fifo (
    .clk   (iol2clk),
    .rst_l (rst_l),
    .push  (push),
    .wdata (pkt_in),
    .pop   (bus.ncu_pkt_rdy),
    .rdata (pkt_out),
    .vld   (bus.ncu_pkt_vld),
    .count (fifo_count)
  );

  assign bus.ncu_sii_gnt  = gnt_q;
  assign bus.ncu_sii_perr = sii_perr_q;
  assign bus.ncu_pkt_cnt  = cnt_q;
  assign bus.ncu_pkt_hdr  = pkt_out.hdr;
  assign bus.ncu_pkt_data = pkt_out.data;
  assign bus.ncu_pkt_perr = pkt_out.perr;

endmodule
